// File: rtl/board_store.sv
// Board occupancy memory for the 10x20 playfield with a built-in line-clear engine.
// Serves a collision read port, one-cell lock writes, a painter read port and a row-0 flag.
module board_store #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] board_rx,
    input  logic [4:0] board_ry,
    output logic       board_rdata,
    input  logic       board_we,
    input  logic [3:0] board_wx,
    input  logic [4:0] board_wy,
    input  logic       board_wdata,
    input  logic       clear_start,
    output logic       busy,
    output logic       clear_done,
    output logic [4:0] lines_cleared,
    output logic [7:0] total_lines,
    input  logic [3:0] vga_x,
    input  logic [4:0] vga_y,
    output logic       vga_cell,
    output logic       top_occupied
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_e;

    state_e            state_q, state_d;
    logic [COLS-1:0]   row_q [ROWS];
    logic [COLS-1:0]   row_d [ROWS];
    logic [4:0]        sr_q, sr_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [4:0]        lines_q, lines_d;
    logic [7:0]        total_q, total_d;
    logic [8:0]        total_sum_s;
    logic              wr_ok_s;
    logic              row_full_s;

    assign wr_ok_s    = (state_q == IDLE) && board_we &&
                        (board_wx < 4'(COLS)) && (board_wy < 5'(ROWS));
    assign row_full_s = &row_q[sr_q];

    // State, storage and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= 5'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lines_q <= 5'd0;
            total_q <= 8'd0;
            for (int r = 0; r < ROWS; r++) begin
                row_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lines_q <= lines_d;
            total_q <= total_d;
            for (int r = 0; r < ROWS; r++) begin
                row_q[r] <= row_d[r];
            end
        end
    end

    // Next-state logic: scan from the bottom row, revisiting a row after each shift.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = SCAN;
                    sr_d    = 5'(ROWS - 1);
                    cnt_d   = 5'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (row_full_s) begin
                    state_d = SHIFT;
                end else if (sr_q == 5'd0) begin
                    state_d = DONE;
                end else begin
                    sr_d = sr_q - 5'd1;
                end
            end
            SHIFT: begin
                state_d = SCAN;
                cnt_d   = cnt_q + 5'd1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Board contents: lock writes in IDLE, collapse rows 0..sr by one in SHIFT.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_d[r] = row_q[r];
        end
        case (state_q)
            IDLE: begin
                if (wr_ok_s) begin
                    row_d[board_wy][board_wx] = board_wdata;
                end else begin
                    row_d[0] = row_q[0];
                end
            end
            SHIFT: begin
                for (int r = 1; r < ROWS; r++) begin
                    if (5'(r) <= sr_q) begin
                        row_d[r] = row_q[r-1];
                    end else begin
                        row_d[r] = row_q[r];
                    end
                end
                row_d[0] = '0;
            end
            default: begin
                row_d[0] = row_q[0];
            end
        endcase
    end

    // Moore outputs computed from the next state so they are registered.
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        total_sum_s = {1'b0, total_q} + {4'd0, cnt_q};
        if (state_d == DONE) begin
            lines_d = cnt_q;
            total_d = (total_sum_s > 9'd255) ? 8'd255 : total_sum_s[7:0];
        end else begin
            lines_d = lines_q;
            total_d = total_q;
        end
    end

    // Out-of-range reads act as a wall for collision and as empty for painting.
    always_comb begin
        if ((board_rx >= 4'(COLS)) || (board_ry >= 5'(ROWS))) begin
            board_rdata = 1'b1;
        end else begin
            board_rdata = row_q[board_ry][board_rx];
        end
        if ((vga_x >= 4'(COLS)) || (vga_y >= 5'(ROWS))) begin
            vga_cell = 1'b0;
        end else begin
            vga_cell = row_q[vga_y][vga_x];
        end
    end

    assign top_occupied  = |row_q[0];
    assign busy          = busy_q;
    assign clear_done    = done_q;
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;

endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store: directed scenarios plus randomized boards
// compared against a row-compaction reference model.
module tb_board_store;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] board_rx = 4'd0;
    logic [4:0] board_ry = 5'd0;
    logic       board_rdata;
    logic       board_we = 1'b0;
    logic [3:0] board_wx = 4'd0;
    logic [4:0] board_wy = 5'd0;
    logic       board_wdata = 1'b0;
    logic       clear_start = 1'b0;
    logic       busy;
    logic       clear_done;
    logic [4:0] lines_cleared;
    logic [7:0] total_lines;
    logic [3:0] vga_x = 4'd0;
    logic [4:0] vga_y = 5'd0;
    logic       vga_cell;
    logic       top_occupied;

    int checks = 0;
    int errors = 0;
    bit model [20][10];
    int m_total = 0;

    board_store dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
        .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy), .board_wdata(board_wdata),
        .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
        .lines_cleared(lines_cleared), .total_lines(total_lines),
        .vga_x(vga_x), .vga_y(vga_y), .vga_cell(vga_cell), .top_occupied(top_occupied)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick;
        @(negedge CLOCK_50);
    endtask

    task automatic write_cell(input int x, input int y, input bit v);
        board_we = 1'b1; board_wx = 4'(x); board_wy = 5'(y); board_wdata = v;
        tick();
        board_we = 1'b0;
    endtask

    task automatic set_cell(input int x, input int y, input bit v);
        model[y][x] = v;
        write_cell(x, y, v);
    endtask

    task automatic load_model;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                write_cell(x, y, model[y][x]);
    endtask

    task automatic zero_model;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                model[y][x] = 1'b0;
    endtask

    // Reference clear: drop every full row and pack the rest toward the bottom.
    task automatic model_clear(output int k);
        bit nb [20][10];
        int dst;
        bit full;
        k = 0;
        dst = 19;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                nb[y][x] = 1'b0;
        for (int y = 19; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < 10; x++)
                if (!model[y][x]) full = 1'b0;
            if (full) k++;
            else begin
                for (int x = 0; x < 10; x++) nb[dst][x] = model[y][x];
                dst--;
            end
        end
        model = nb;
        m_total = (m_total + k > 255) ? 255 : m_total + k;
    endtask

    function automatic bit model_top();
        bit t = 1'b0;
        for (int x = 0; x < 10; x++) t |= model[0][x];
        return t;
    endfunction

    task automatic board_diff(output int nbad);
        nbad = 0;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) begin
                vga_x = 4'(x); vga_y = 5'(y);
                #1;
                if (vga_cell !== model[y][x]) nbad++;
            end
        tick();
    endtask

    // Pulse clear_start and count cycles until clear_done; -1 if it never comes.
    task automatic run_clear(output int done_cyc, output int busy_bad);
        busy_bad = 0;
        done_cyc = -1;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (busy !== 1'b1) busy_bad++;
            if (clear_done === 1'b1) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic check_clear(input string name, input int k, input int done_cyc, input int busy_bad);
        int nbad;
        checks++;
        if (done_cyc !== 21 + 2 * k) begin
            errors++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, 21 + 2 * k);
        end
        checks++;
        if (busy_bad !== 0 || busy !== 1'b0 || clear_done !== 1'b0) begin
            errors++; $display("FAIL %s busy_profile bad=%0d busy=%b done=%b want 0/0/0", name, busy_bad, busy, clear_done);
        end
        checks++;
        if (lines_cleared !== 5'(k)) begin
            errors++; $display("FAIL %s lines_cleared got %0d want %0d", name, lines_cleared, k);
        end
        checks++;
        if (total_lines !== 8'(m_total)) begin
            errors++; $display("FAIL %s total_lines got %0d want %0d", name, total_lines, m_total);
        end
        board_diff(nbad);
        checks++;
        if (nbad !== 0) begin
            errors++; $display("FAIL %s board_cells got %0d wrong want 0", name, nbad);
        end
        checks++;
        if (top_occupied !== model_top()) begin
            errors++; $display("FAIL %s top_occupied got %b want %b", name, top_occupied, model_top());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        zero_model(); m_total = 0;
        board_rx = 4'd5; board_ry = 5'd10; #1;
        checks++;
        if ({busy, clear_done, lines_cleared, total_lines, top_occupied, board_rdata} !== 16'd0) begin
            errors++; $display("FAIL reset_outputs got %b/%b/%0d/%0d/%b/%b want all 0", busy, clear_done,
                               lines_cleared, total_lines, top_occupied, board_rdata);
        end
        tick();
    endtask

    task automatic test_rw;
        set_cell(3, 19, 1'b1);
        board_rx = 4'd3; board_ry = 5'd19; #1;
        checks++;
        if (board_rdata !== 1'b1) begin errors++; $display("FAIL rw_readback got %b want 1", board_rdata); end
        board_rx = 4'd10; board_ry = 5'd0; #1;
        checks++;
        if (board_rdata !== 1'b1) begin errors++; $display("FAIL rw_rx_wall got %b want 1", board_rdata); end
        board_rx = 4'd0; board_ry = 5'd20; #1;
        checks++;
        if (board_rdata !== 1'b1) begin errors++; $display("FAIL rw_ry_wall got %b want 1", board_rdata); end
        vga_x = 4'd10; vga_y = 5'd0; #1;
        checks++;
        if (vga_cell !== 1'b0) begin errors++; $display("FAIL rw_vga_oob got %b want 0", vga_cell); end
        tick();
        write_cell(12, 0, 1'b1);
        checks++;
        if (top_occupied !== 1'b0) begin errors++; $display("FAIL rw_oob_write got %b want 0", top_occupied); end
        set_cell(7, 0, 1'b1);
        checks++;
        if (top_occupied !== 1'b1) begin errors++; $display("FAIL rw_top_set got %b want 1", top_occupied); end
        set_cell(7, 0, 1'b0);
        set_cell(3, 19, 1'b0);
        checks++;
        if (top_occupied !== 1'b0) begin errors++; $display("FAIL rw_top_clr got %b want 0", top_occupied); end
    endtask

    task automatic test_single_line;
        int k, dc, bb;
        for (int x = 0; x < 10; x++) set_cell(x, 19, 1'b1);
        set_cell(4, 18, 1'b1);
        model_clear(k);
        run_clear(dc, bb);
        check_clear("single", k, dc, bb);
        board_rx = 4'd4; board_ry = 5'd19; #1;
        checks++;
        if (board_rdata !== 1'b1) begin errors++; $display("FAIL single_drop got %b want 1", board_rdata); end
        tick();
    endtask

    task automatic test_four_lines;
        int k, dc, bb;
        for (int y = 16; y < 20; y++)
            for (int x = 0; x < 10; x++) model[y][x] = 1'b1;
        model[15][0] = 1'b1;
        load_model();
        model_clear(k);
        run_clear(dc, bb);
        check_clear("four", k, dc, bb);
    endtask

    task automatic test_split_lines;
        int k, dc, bb;
        zero_model();
        for (int x = 0; x < 10; x++) begin model[19][x] = 1'b1; model[17][x] = 1'b1; end
        load_model();
        model_clear(k);
        run_clear(dc, bb);
        check_clear("split", k, dc, bb);
    endtask

    task automatic test_random;
        int k, dc, bb, mode;
        for (int it = 0; it < 16; it++) begin
            for (int y = 0; y < 20; y++) begin
                mode = (y < 4) ? 1 : int'($urandom_range(0, 3));
                for (int x = 0; x < 10; x++)
                    model[y][x] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            if (it == 3) model[0][$urandom_range(0, 9)] = 1'b1;
            load_model();
            model_clear(k);
            run_clear(dc, bb);
            check_clear("random", k, dc, bb);
        end
    endtask

    task automatic test_busy;
        int dc, extra;
        zero_model();
        load_model();
        dc = -1;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 3) begin
                board_we = 1'b1; board_wx = 4'd0; board_wy = 5'd0; board_wdata = 1'b1; clear_start = 1'b1;
            end else begin
                board_we = 1'b0; clear_start = 1'b0;
            end
            if (clear_done === 1'b1) begin dc = c; break; end
            tick();
        end
        board_we = 1'b0; clear_start = 1'b0;
        tick();
        checks++;
        if (dc !== 21) begin errors++; $display("FAIL busy_done_cycle got %0d want 21", dc); end
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            if (clear_done !== 1'b0 || busy !== 1'b0) extra++;
            tick();
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL busy_requeue got %0d active cycles want 0", extra); end
        board_rx = 4'd0; board_ry = 5'd0; #1;
        checks++;
        if (board_rdata !== 1'b0) begin errors++; $display("FAIL busy_write_drop got %b want 0", board_rdata); end
        tick();
    endtask

    task automatic test_reset_mid;
        int seen, nbad;
        for (int x = 0; x < 10; x++) set_cell(x, 19, 1'b1);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        zero_model(); m_total = 0;
        checks++;
        if ({busy, clear_done, lines_cleared, total_lines} !== 15'd0) begin
            errors++; $display("FAIL reset_mid_outputs got busy=%b done=%b lines=%0d total=%0d want 0", busy,
                               clear_done, lines_cleared, total_lines);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (clear_done !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d pulses want 0", seen); end
        board_diff(nbad);
        checks++;
        if (nbad !== 0) begin errors++; $display("FAIL reset_mid_board got %0d wrong want 0", nbad); end
    endtask

    task automatic test_saturate;
        int k, dc, bb, bad_lat;
        bad_lat = 0;
        for (int n = 0; n < 65; n++) begin
            for (int y = 16; y < 20; y++)
                for (int x = 0; x < 10; x++) set_cell(x, y, 1'b1);
            model_clear(k);
            run_clear(dc, bb);
            if (dc != 29 || lines_cleared !== 5'd4) bad_lat++;
            if (n == 62) begin
                checks++;
                if (total_lines !== 8'(m_total)) begin
                    errors++; $display("FAIL sat_pre got %0d want %0d", total_lines, m_total);
                end
            end
        end
        checks++;
        if (bad_lat !== 0) begin errors++; $display("FAIL sat_clears got %0d bad clears want 0", bad_lat); end
        checks++;
        if (total_lines !== 8'(m_total)) begin
            errors++; $display("FAIL sat_hold got %0d want %0d", total_lines, m_total);
        end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_single_line();
        test_four_lines();
        test_split_lines();
        test_random();
        test_busy();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
